mac_out_fifo: RTL

//  Output buffer directly downstream of the square-accumulate MAC stage.

---
 rtl/mac_pkg.sv | 13 +
 rtl/fifo_mem.sv | 34 +++
 rtl/mac_out_fifo.sv | 118 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mac_pkg                                                         |
// | Brief  : Widths and types shared by the square-accumulate MAC and FIFO.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package mac_pkg;
  localparam int MAC_IN_W  = 8;
  localparam int MAC_ACC_W = 20;

  typedef logic [MAC_ACC_W-1:0] acc_t;
endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fifo_mem                                                        |
// | Brief  : DEPTH x WIDTH register array, sync write port, async read port. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module fifo_mem
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_ACC_W,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are never reset; the control logic tracks which entries are live.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/mac_out_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mac_out_fifo                                                    |
// | Brief  : Show-ahead output FIFO after the MAC; drops on full and flags a |
// |          sticky overflow. MAC_FIFO_DROP_CNT_EN adds a saturating         |
// |          drop_count output.                                              |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module mac_out_fifo
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_ACC_W,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             f_in,
  input  logic                         valid_in,
  input  logic                         ready_in,
  output logic [WIDTH-1:0]             data_out,
  output logic                         valid_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow
`ifdef MAC_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]                   drop_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH-1);
  localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             w_pop, w_push, w_drop, w_full, w_nempty;
  logic [WIDTH-1:0] w_rdata;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  assign w_nempty = (count_q != '0);
  assign w_full   = (count_q == c_full_cnt);
  assign w_pop    = w_nempty & ready_in;
  assign w_push   = valid_in & (~w_full | w_pop);
  assign w_drop   = valid_in & w_full & ~w_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | w_drop;
    if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push & ~reset),
    .waddr (wr_ptr_q),
    .wdata (f_in),
    .raddr (rd_ptr_q),
    .rdata (w_rdata)
  );

  assign data_out  = w_nempty ? w_rdata : '0;
  assign valid_out = w_nempty;
  assign count     = count_q;
  assign full      = w_full;
  assign overflow  = overflow_q;

`ifdef MAC_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
`default_nettype wire
